timer_mmio: RTL

Memory-mapped countdown timer: a bus responder for the CPU's data-memory port, decoding CNT (002h–003h) and CTRL (004h–005h). It decrements CNT once per tick of a fixed prescaler. It raises IF when CNT reaches zero and drives `irq` = IF & IE toward the CPU interrupt input. The top level ORs its `rd_data` with the other responders.

---
 rtl/timer_mmio_pkg.sv | 36 +++
 rtl/timer_mmio_tick_gen.sv | 29 ++
 rtl/timer_mmio.sv | 120 ++++++++++++
 3 files changed

// File: rtl/timer_mmio_pkg.sv
// Shared constants and lane helpers for the countdown timer.
// Imported by the timer top and its prescaler.
package timer_mmio_pkg;

  localparam logic [11:0] TIMER_CNT_ADDR  = 12'h002;
  localparam logic [11:0] TIMER_CTRL_ADDR = 12'h004;
  localparam int          TIMER_IF_BIT    = 0;
  localparam int          TIMER_IE_BIT    = 1;

  typedef struct packed {
    logic hi;
    logic lo;
  } lane_en_t;

  // Word access to an odd address degrades to a high-lane byte.
  function automatic lane_en_t lane_en(
    input logic byt,
    input logic a0
  );
    lane_en_t l;
    l.lo = ~a0;
    l.hi = a0 | ~byt;
    return l;
  endfunction

  function automatic logic [15:0] merge_lanes(
    input logic [15:0] old_v,
    input logic [15:0] new_v,
    input lane_en_t    en
  );
    logic [15:0] mask;
    mask = {{8{en.hi}}, {8{en.lo}}};
    return (old_v & ~mask) | (new_v & mask);
  endfunction

endpackage

// File: rtl/timer_mmio_tick_gen.sv
// Free-running prescaler: one-cycle tick every PRESCALE clocks.
// Shared with the UART baud generator.
module tick_gen #(
  parameter int PRESCALE = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);

  localparam int W = $clog2(PRESCALE);
  localparam logic [W-1:0] LAST = W'(PRESCALE - 1);

  logic [W-1:0] count;

  assign tick = (count == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear || tick) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/timer_mmio.sv
// Memory-mapped countdown timer with CNT/CTRL registers and a level irq.
// Read data is registered and zero when unselected so it can be OR-ed.
module timer_mmio
  import timer_mmio_pkg::*;
#(
  parameter int CLOCK_HZ   = 27_000_000,
  parameter int TICK_HZ    = 1000,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  wr_mem,
  input  logic                  byt,
  input  logic [15:0]           wr_data,
  output logic [15:0]           rd_data,
  output logic                  irq
);

  localparam int PRESCALE = CLOCK_HZ / TICK_HZ;

  localparam logic [ADDR_WIDTH-1:0] CNT_A =
    ADDR_WIDTH'(TIMER_CNT_ADDR);
  localparam logic [ADDR_WIDTH-1:0] CTRL_A =
    ADDR_WIDTH'(TIMER_CTRL_ADDR);

  logic        sel_cnt;
  logic        sel_ctrl;
  lane_en_t    len;
  logic        wr_cnt;
  logic        wr_ctrl;
  logic        tick;
  logic        cnt_dec;
  logic        if_set;

  logic [15:0] cnt_q;
  logic [15:0] cnt_d;
  logic        if_q;
  logic        if_d;
  logic        ie_q;
  logic        ie_d;
  logic [15:0] ctrl_word;
  logic [15:0] rd_d;

  assign sel_cnt  =
    (mem_addr[ADDR_WIDTH-1:1] == CNT_A[ADDR_WIDTH-1:1]);
  assign sel_ctrl =
    (mem_addr[ADDR_WIDTH-1:1] == CTRL_A[ADDR_WIDTH-1:1]);
  assign len      = lane_en(byt, mem_addr[0]);

  assign wr_cnt   = wr_mem & sel_cnt;
  assign wr_ctrl  = wr_mem & sel_ctrl & len.lo;

  // A CNT write pre-empts the tick, so no decrement that cycle.
  assign cnt_dec  = tick & ~wr_cnt & (cnt_q != 16'd0);
  assign if_set   = cnt_dec & (cnt_q == 16'd1);

  tick_gen #(
    .PRESCALE(PRESCALE)
  ) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .clear(wr_cnt),
    .tick (tick)
  );

  always_comb begin
    cnt_d = cnt_q;
    if (wr_cnt) begin
      cnt_d = merge_lanes(cnt_q, wr_data, len);
    end else if (cnt_dec) begin
      cnt_d = cnt_q - 16'd1;
    end
  end

  // Hardware set beats a software clear so no interrupt is lost.
  always_comb begin
    if_d = if_q;
    ie_d = ie_q;
    if (wr_ctrl) begin
      if_d = wr_data[TIMER_IF_BIT];
      ie_d = wr_data[TIMER_IE_BIT];
    end
    if (if_set) begin
      if_d = 1'b1;
    end
  end

  always_comb begin
    ctrl_word = '0;
    ctrl_word[TIMER_IF_BIT] = if_q;
    ctrl_word[TIMER_IE_BIT] = ie_q;
  end

  always_comb begin
    rd_d = '0;
    unique case (1'b1)
      sel_cnt:  rd_d = cnt_q;
      sel_ctrl: rd_d = ctrl_word;
      default:  rd_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      if_q    <= 1'b0;
      ie_q    <= 1'b0;
      rd_data <= '0;
    end else begin
      cnt_q   <= cnt_d;
      if_q    <= if_d;
      ie_q    <= ie_d;
      rd_data <= rd_d;
    end
  end

  assign irq = if_q & ie_q;

endmodule
